// File: rtl/looper_spart_pkg.sv
// Shared definitions for the SPART host-command front end: command and
// response byte codes, FSM state encodings and a command-decode helper.
package looper_spart_pkg;

    localparam logic [7:0] CMD_START = 8'h73;  // 's'
    localparam logic [7:0] CMD_WRITE = 8'h77;  // 'w'
    localparam logic [7:0] CMD_CLEAR = 8'h63;  // 'c'

    localparam logic [7:0] RESP_ACK  = 8'h06;
    localparam logic [7:0] RESP_NAK  = 8'h15;

    // Encodings are visible on the debug/LED port, so they are fixed values.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CLR_MEM  = 4'd1,
        ST_GET_ADDR = 4'd2,
        ST_GET_DATA = 4'd3,
        ST_MEM_WR   = 4'd4,
        ST_START    = 4'd5,
        ST_TX_RESP  = 4'd8
    } state_e;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_START) || (b == CMD_WRITE) || (b == CMD_CLEAR);
    endfunction

endpackage

// File: rtl/spart_shift_acc.sv
// Byte shift-accumulator: assembles NBYTES big-endian bytes into one word.
// last_o flags the strobe that carries the final byte; value_next_o is the
// word as it will be once that byte is shifted in.
module spart_shift_acc #(
    parameter int NBYTES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  shift_i,
    input  logic [7:0]            byte_i,
    output logic [8*NBYTES-1:0]   value_o,
    output logic [8*NBYTES-1:0]   value_next_o,
    output logic                  last_o
);
    localparam int W     = 8 * NBYTES;
    localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [W-1:0]     value_q, value_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    generate
        if (NBYTES == 1) begin : g_single
            assign value_next_o = byte_i;
        end else begin : g_multi
            assign value_next_o = {value_q[W-9:0], byte_i};
        end
    endgenerate

    assign last_o  = shift_i && (cnt_q == CNT_W'(NBYTES - 1));
    assign value_o = value_q;

    // Shift on each strobe; the counter wraps after the final byte so the
    // next field starts from zero without an explicit clear.
    always_comb begin
        value_d = value_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (shift_i) begin
            value_d = value_next_o;
            cnt_d   = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Byte and counter state; reset discards any partial operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            cnt_q   <= '0;
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/spart_cmd_loader.sv
// SPART host-command loader: decodes 's' (start CPU at PC), 'w' (write one
// data word) and 'c' (clear memory) frames and answers each with ACK/NAK.
// Optional build macro SPART_TIMEOUT_EN aborts a stalled operand with NAK
// after TIMEOUT_CYC idle clocks.
module spart_cmd_loader
    import looper_spart_pkg::*;
#(
    parameter int ADDR_BYTES  = 8,
    parameter int DATA_BYTES  = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                    clk_100mhz,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [8*ADDR_BYTES-1:0] mem_addr,
    output logic [8*DATA_BYTES-1:0] mem_wdata,
    output logic                    mem_we,
    input  logic                    mem_ack,
    output logic                    clr_mem,
    input  logic                    clr_done,
    output logic                    cpu_start,
    output logic [8*ADDR_BYTES-1:0] cpu_pc,
    output logic [3:0]              state,
    output logic                    err
);
    localparam int ADDR_W = 8 * ADDR_BYTES;
    localparam int DATA_W = 8 * DATA_BYTES;

    state_e            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] cpu_pc_q, cpu_pc_d;

    logic [ADDR_W-1:0] addr_val, addr_next;
    logic [DATA_W-1:0] data_val, data_next_unused;
    logic              addr_last, data_last;
    logic              in_idle, in_operand, tmo_fire;

    assign in_idle    = (state_q == ST_IDLE);
    assign in_operand = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);

    spart_shift_acc #(.NBYTES(ADDR_BYTES)) u_addr_acc (
        .clk          (clk_100mhz),
        .rst_n        (rst_n),
        .clr_i        (in_idle),
        .shift_i      (rx_valid && (state_q == ST_GET_ADDR)),
        .byte_i       (rx_data),
        .value_o      (addr_val),
        .value_next_o (addr_next),
        .last_o       (addr_last)
    );

    spart_shift_acc #(.NBYTES(DATA_BYTES)) u_data_acc (
        .clk          (clk_100mhz),
        .rst_n        (rst_n),
        .clr_i        (in_idle),
        .shift_i      (rx_valid && (state_q == ST_GET_DATA)),
        .byte_i       (rx_data),
        .value_o      (data_val),
        .value_next_o (data_next_unused),
        .last_o       (data_last)
    );

`ifdef SPART_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign tmo_d    = (!in_operand || rx_valid) ? '0 : tmo_q + 1'b1;
    assign tmo_fire = in_operand && !rx_valid && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    // Inter-byte idle counter, restarted by every received operand byte.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    // Without the timeout feature the limit has no effect.
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYC;
    assign tmo_fire       = 1'b0;
`endif

    // FSM state register plus the registered response/error/PC context.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            tx_data_q <= '0;
            err_q     <= 1'b0;
            cpu_pc_q  <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            tx_data_q <= tx_data_d;
            err_q     <= err_d;
            cpu_pc_q  <= cpu_pc_d;
        end
    end

    // Next-state decode; cpu_pc is loaded from the completing address byte
    // so it is already valid during the start pulse.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        tx_data_d = tx_data_q;
        err_d     = err_q;
        cpu_pc_d  = cpu_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (is_cmd(rx_data)) begin
                        cmd_d   = rx_data;
                        err_d   = 1'b0;
                        state_d = (rx_data == CMD_CLEAR) ? ST_CLR_MEM : ST_GET_ADDR;
                    end else begin
                        err_d     = 1'b1;
                        tx_data_d = RESP_NAK;
                        state_d   = ST_TX_RESP;
                    end
                end
            end
            ST_GET_ADDR: begin
                if (tmo_fire) begin
                    err_d     = 1'b1;
                    tx_data_d = RESP_NAK;
                    state_d   = ST_TX_RESP;
                end else if (addr_last) begin
                    if (cmd_q == CMD_START) begin
                        cpu_pc_d = addr_next;
                        state_d  = ST_START;
                    end else begin
                        state_d  = ST_GET_DATA;
                    end
                end
            end
            ST_GET_DATA: begin
                if (tmo_fire) begin
                    err_d     = 1'b1;
                    tx_data_d = RESP_NAK;
                    state_d   = ST_TX_RESP;
                end else if (data_last) begin
                    state_d = ST_MEM_WR;
                end
            end
            ST_MEM_WR: begin
                if (rx_valid) err_d = 1'b1;
                if (mem_ack) begin
                    tx_data_d = RESP_ACK;
                    state_d   = ST_TX_RESP;
                end
            end
            ST_CLR_MEM: begin
                if (rx_valid) err_d = 1'b1;
                if (clr_done) begin
                    tx_data_d = RESP_ACK;
                    state_d   = ST_TX_RESP;
                end
            end
            ST_START: begin
                if (rx_valid) err_d = 1'b1;
                tx_data_d = RESP_ACK;
                state_d   = ST_TX_RESP;
            end
            ST_TX_RESP: begin
                if (rx_valid) err_d = 1'b1;
                if (tx_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore request outputs decoded from the current state.
    always_comb begin
        tx_valid  = (state_q == ST_TX_RESP);
        mem_we    = (state_q == ST_MEM_WR);
        clr_mem   = (state_q == ST_CLR_MEM);
        cpu_start = (state_q == ST_START);
    end

    assign tx_data   = tx_data_q;
    assign mem_addr  = addr_val;
    assign mem_wdata = data_val;
    assign cpu_pc    = cpu_pc_q;
    assign state     = state_q;
    assign err       = err_q;

endmodule

// File: tb/tb_spart_cmd_loader.sv
// Directed testbench for spart_cmd_loader with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_spart_cmd_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [63:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_ack;
    logic        clr_mem;
    logic        clr_done;
    logic        cpu_start;
    logic [63:0] cpu_pc;
    logic [3:0]  state;
    logic        err;

    int n_chk  = 0;
    int n_bad  = 0;
    int starts = 0;

    always #5 clk = ~clk;

    spart_cmd_loader #(
        .ADDR_BYTES  (8),
        .DATA_BYTES  (2),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk_100mhz (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .clr_mem    (clr_mem),
        .clr_done   (clr_done),
        .cpu_start  (cpu_start),
        .cpu_pc     (cpu_pc),
        .state      (state),
        .err        (err)
    );

    // Count start pulses as seen on each falling edge.
    always @(negedge clk) if (rst_n && cpu_start) starts++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send_byte(8'h00);
    endtask

    initial begin
        int s0;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        mem_ack  = 1'b0;
        clr_done = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check_eq("rst_state", state, 0);
        check_eq("rst_outs", {tx_valid, mem_we, clr_mem, cpu_start, err}, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_cpu_pc", cpu_pc, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        rst_n = 1'b1;

        // Start frame, PC = 4
        s0 = starts;
        send_byte(8'h73);
        check_eq("s_get_addr", state, 2);
        send_zeros(7);
        check_eq("s_still_addr", state, 2);
        send_byte(8'h04);
        check_eq("s_state_start", state, 5);
        check_eq("s_cpu_start", cpu_start, 1);
        check_eq("s_cpu_pc", cpu_pc, 64'h4);
        @(negedge clk);
        check_eq("s_pulse_end", cpu_start, 0);
        check_eq("s_state_tx", state, 8);
        check_eq("s_tx_valid", tx_valid, 1);
        check_eq("s_tx_ack", tx_data, 8'h06);
        check_eq("s_pc_hold", cpu_pc, 64'h4);
        @(negedge clk);
        check_eq("s_idle", state, 0);
        check_eq("s_tx_drop", tx_valid, 0);
        check_eq("s_one_pulse", starts - s0, 1);

        // Write frame, addr 0x10, data 0xBEEF
        send_byte(8'h77);
        send_zeros(7);
        send_byte(8'h10);
        check_eq("w_get_data", state, 3);
        send_byte(8'hBE);
        send_byte(8'hEF);
        check_eq("w_state_wr", state, 4);
        check_eq("w_mem_we", mem_we, 1);
        check_eq("w_addr", mem_addr, 64'h10);
        check_eq("w_wdata", mem_wdata, 16'hBEEF);
        repeat (5) @(negedge clk);
        check_eq("w_we_held", mem_we, 1);
        check_eq("w_addr_stable", mem_addr, 64'h10);
        check_eq("w_wdata_stable", mem_wdata, 16'hBEEF);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_eq("w_we_low", mem_we, 0);
        check_eq("w_state_tx", state, 8);
        check_eq("w_tx_ack", {tx_valid, tx_data}, {1'b1, 8'h06});
        @(negedge clk);
        check_eq("w_idle", state, 0);

        // Stray ack while idle is ignored
        mem_ack  = 1'b1;
        clr_done = 1'b1;
        @(negedge clk);
        mem_ack  = 1'b0;
        clr_done = 1'b0;
        check_eq("stray_ack_idle", state, 0);
        check_eq("stray_ack_err", err, 0);

        // Clear frame with transmitter back-pressure
        tx_ready = 1'b0;
        send_byte(8'h63);
        check_eq("c_state", state, 1);
        check_eq("c_clr_mem", clr_mem, 1);
        repeat (3) @(negedge clk);
        check_eq("c_clr_held", clr_mem, 1);
        clr_done = 1'b1;
        @(negedge clk);
        clr_done = 1'b0;
        check_eq("c_clr_low", clr_mem, 0);
        check_eq("c_state_tx", state, 8);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("c_tx_stable", {tx_valid, tx_data, state}, {1'b1, 8'h06, 4'd8});
        end
        send_byte(8'h77);
        check_eq("c_drop_err", err, 1);
        check_eq("c_drop_state", state, 8);
        tx_ready = 1'b1;
        @(negedge clk);
        check_eq("c_idle", state, 0);
        check_eq("c_tx_drop", tx_valid, 0);

        // Bad command, then a good frame clears err
        send_byte(8'h5A);
        check_eq("bad_state", state, 8);
        check_eq("bad_nak", {tx_valid, tx_data}, {1'b1, 8'h15});
        check_eq("bad_err", err, 1);
        @(negedge clk);
        check_eq("bad_idle", state, 0);
        check_eq("bad_err_sticky", err, 1);
        send_byte(8'h73);
        check_eq("good_err_clr", err, 0);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        check_eq("good_start", cpu_start, 1);
        check_eq("good_pc", cpu_pc, 64'h0102030405060708);
        @(negedge clk);
        check_eq("good_ack", tx_data, 8'h06);
        @(negedge clk);
        check_eq("good_idle", state, 0);

        // Reset in the middle of an address
        send_byte(8'h73);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_state", state, 0);
        check_eq("mid_rst_outs", {tx_valid, mem_we, clr_mem, cpu_start, err}, 0);
        check_eq("mid_rst_addr", mem_addr, 0);
        check_eq("mid_rst_pc", cpu_pc, 0);
        check_eq("mid_rst_tx", tx_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = starts;
        send_byte(8'h73);
        send_zeros(7);
        send_byte(8'h09);
        check_eq("post_rst_pc", cpu_pc, 64'h9);
        check_eq("post_rst_start", cpu_start, 1);
        @(negedge clk);
        @(negedge clk);
        check_eq("post_rst_idle", state, 0);
        check_eq("post_rst_pulses", starts - s0, 1);

`ifdef SPART_TIMEOUT_EN
        // Stalled operand times out after 100 idle clocks
        s0 = starts;
        send_byte(8'h73);
        send_byte(8'h00);
        repeat (99) @(negedge clk);
        check_eq("tmo_waiting", state, 2);
        @(negedge clk);
        check_eq("tmo_state_tx", state, 8);
        check_eq("tmo_nak", {tx_valid, tx_data}, {1'b1, 8'h15});
        check_eq("tmo_err", err, 1);
        @(negedge clk);
        check_eq("tmo_idle", state, 0);
        check_eq("tmo_no_start", starts - s0, 0);
`else
        // Without the timeout a partial frame simply waits
        send_byte(8'h73);
        send_byte(8'h00);
        repeat (150) @(negedge clk);
        check_eq("no_tmo_wait", state, 2);
        check_eq("no_tmo_err", err, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
